// File: rtl/tset_aging_ctrl_pkg.sv
// Shared types for the topic-subscription expiry table and its aging scanner.
// Entry/address types here describe the default table geometry.
package tset_aging_ctrl_pkg;

  localparam int TID_NBITS_DEF          = 10;
  localparam int SCI_NBITS_DEF          = 4;
  localparam int SUB_EXP_TIME_NBITS_DEF = 16;
  localparam int TSET_ADDR_NBITS        = TID_NBITS_DEF + SCI_NBITS_DEF;

  typedef struct packed {
    logic                              valid;
    logic [SUB_EXP_TIME_NBITS_DEF-1:0] exp_time;
  } tset_entry_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EVAL,
    ST_CLR,
    ST_NOTIFY,
    ST_WAIT
  } aging_state_e;

endpackage

// File: rtl/tset_expiry_cmp.sv
// Wrap-safe expiry test: an entry is expired when now is strictly ahead of
// exp_time by less than half the time-base range.
module tset_expiry_cmp #(
  parameter int SUB_EXP_TIME_NBITS = 16
) (
  input  logic [SUB_EXP_TIME_NBITS-1:0] now_sub,
  input  logic                          valid,
  input  logic [SUB_EXP_TIME_NBITS-1:0] exp_time,
  output logic                          expired
);

  logic [SUB_EXP_TIME_NBITS-1:0] diff;

  assign diff    = now_sub - exp_time;
  assign expired = valid && (diff != '0) && !diff[SUB_EXP_TIME_NBITS-1];

endmodule

// File: rtl/tset_aging_ctrl.sv
// Expiry table controller: arbitrates the RAM write port between refreshes
// and a background scanner that clears and reports expired {tid, sci} entries.
module tset_aging_ctrl
  import tset_aging_ctrl_pkg::*;
#(
  parameter int TID_NBITS          = 10,
  parameter int SCI_NBITS          = 4,
  parameter int SUB_EXP_TIME_NBITS = 16,
  parameter int REAL_TIME_NBITS    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REAL_TIME_NBITS-1:0]         current_time,
  input  logic                               scan_enable,
  input  logic [15:0]                        scan_gap,
  input  logic                               tset_wr,
  input  logic [TID_NBITS+SCI_NBITS-1:0]     tset_waddr,
  input  logic [SUB_EXP_TIME_NBITS-1:0]      tset_wdata,
  output logic                               tset_ram_rd,
  output logic [TID_NBITS+SCI_NBITS-1:0]     tset_ram_raddr,
  input  logic [SUB_EXP_TIME_NBITS:0]        tset_ram_rdata,
  output logic                               tset_ram_wr,
  output logic [TID_NBITS+SCI_NBITS-1:0]     tset_ram_waddr,
  output logic [SUB_EXP_TIME_NBITS:0]        tset_ram_wdata,
  output logic                               expire_valid,
  input  logic                               expire_ready,
  output logic [TID_NBITS-1:0]               expire_tid,
  output logic [SCI_NBITS-1:0]               expire_sci,
  output logic                               scan_busy,
  output logic                               scan_done,
  output logic [15:0]                        expire_cnt
);

  localparam int AW = TID_NBITS + SCI_NBITS;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  aging_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic          done_q, done_d;
  logic          do_next;
  logic          wr_hit;
  logic          expired;
  logic [SUB_EXP_TIME_NBITS-1:0] now_sub;
  logic          unused_time_bits;

  assign now_sub          = current_time[REAL_TIME_NBITS-1 -: SUB_EXP_TIME_NBITS];
  assign unused_time_bits = ^current_time[REAL_TIME_NBITS-SUB_EXP_TIME_NBITS-1:0];
  assign wr_hit           = tset_wr && (tset_waddr == idx_q);

  tset_expiry_cmp #(.SUB_EXP_TIME_NBITS(SUB_EXP_TIME_NBITS)) u_cmp (
    .now_sub  (now_sub),
    .valid    (tset_ram_rdata[SUB_EXP_TIME_NBITS]),
    .exp_time (tset_ram_rdata[SUB_EXP_TIME_NBITS-1:0]),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    done_d  = 1'b0;
    do_next = 1'b0;
    case (state_q)
      ST_IDLE: if (scan_enable) begin
        idx_d   = '0;
        state_d = ST_RD;
      end
      ST_RD: begin
        if (wr_hit) hit_d = 1'b1;
        state_d = ST_EVAL;
      end
      // A same-cycle refresh also counts: rdata is stale for this entry.
      ST_EVAL: if (expired && !(hit_q || wr_hit)) state_d = ST_CLR;
               else                               do_next = 1'b1;
      ST_CLR: begin
        if (tset_wr) begin
          if (wr_hit) do_next = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_NOTIFY;
        end
      end
      ST_NOTIFY: if (expire_ready) do_next = 1'b1;
      ST_WAIT: begin
        if (!scan_enable)       state_d = ST_IDLE;
        else if (gap_q == '0) begin
          idx_d   = '0;
          state_d = ST_RD;
        end else                gap_d = gap_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_next) begin
      hit_d = 1'b0;
      if (idx_q == LAST_ADDR) begin
        done_d  = 1'b1;
        gap_d   = scan_gap;
        state_d = ST_WAIT;
      end else if (!scan_enable) begin
        state_d = ST_IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_RD;
      end
    end
  end

  always_comb begin
    tset_ram_wr    = 1'b0;
    tset_ram_waddr = '0;
    tset_ram_wdata = '0;
    if (tset_wr) begin
      tset_ram_wr    = 1'b1;
      tset_ram_waddr = tset_waddr;
      tset_ram_wdata = {1'b1, tset_wdata};
    end else if (state_q == ST_CLR) begin
      tset_ram_wr    = 1'b1;
      tset_ram_waddr = idx_q;
    end
  end

  assign tset_ram_rd    = (state_q == ST_RD);
  assign tset_ram_raddr = (state_q == ST_RD) ? idx_q : '0;
  assign expire_valid   = (state_q == ST_NOTIFY);
  assign expire_tid     = idx_q[AW-1 -: TID_NBITS];
  assign expire_sci     = idx_q[SCI_NBITS-1:0];
  assign scan_busy      = (state_q == ST_RD) || (state_q == ST_EVAL) ||
                          (state_q == ST_CLR) || (state_q == ST_NOTIFY);
  assign scan_done      = done_q;
  assign expire_cnt     = cnt_q;

endmodule

// File: tb/tb_tset_aging_ctrl.sv
// Bench for tset_aging_ctrl on a 16-entry table with a behavioural RAM and
// an expiry model computed directly from the time arithmetic.
module tb_tset_aging_ctrl;

  localparam int TID = 2, SCI = 2, EXP = 16, RT = 32, AW = 4, EW = 17, N = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [RT-1:0]  current_time;
  logic           scan_enable;
  logic [15:0]    scan_gap;
  logic           tset_wr;
  logic [AW-1:0]  tset_waddr;
  logic [EXP-1:0] tset_wdata;
  logic           tset_ram_rd;
  logic [AW-1:0]  tset_ram_raddr;
  logic [EW-1:0]  tset_ram_rdata = '0;
  logic           tset_ram_wr;
  logic [AW-1:0]  tset_ram_waddr;
  logic [EW-1:0]  tset_ram_wdata;
  logic           expire_valid, expire_ready;
  logic [TID-1:0] expire_tid;
  logic [SCI-1:0] expire_sci;
  logic           scan_busy, scan_done;
  logic [15:0]    expire_cnt;

  int checks = 0, errors = 0;

  logic [EW-1:0] ram [N];
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [EW-1:0] ld_data;
  logic [AW-1:0] rpt_q [$];

  always #5 clk = ~clk;

  tset_aging_ctrl #(.TID_NBITS(TID), .SCI_NBITS(SCI),
                    .SUB_EXP_TIME_NBITS(EXP), .REAL_TIME_NBITS(RT)) dut (
    .clk(clk), .rst_n(rst_n), .current_time(current_time),
    .scan_enable(scan_enable), .scan_gap(scan_gap),
    .tset_wr(tset_wr), .tset_waddr(tset_waddr), .tset_wdata(tset_wdata),
    .tset_ram_rd(tset_ram_rd), .tset_ram_raddr(tset_ram_raddr),
    .tset_ram_rdata(tset_ram_rdata),
    .tset_ram_wr(tset_ram_wr), .tset_ram_waddr(tset_ram_waddr),
    .tset_ram_wdata(tset_ram_wdata),
    .expire_valid(expire_valid), .expire_ready(expire_ready),
    .expire_tid(expire_tid), .expire_sci(expire_sci),
    .scan_busy(scan_busy), .scan_done(scan_done), .expire_cnt(expire_cnt)
  );

  // Single-port-style RAM: registered read returns pre-write data.
  always @(posedge clk) begin
    if (tset_ram_rd) tset_ram_rdata <= ram[tset_ram_raddr];
    if (ld_wr) ram[ld_addr] <= ld_data;
    else if (tset_ram_wr) ram[tset_ram_waddr] <= tset_ram_wdata;
  end

  always @(negedge clk)
    if (rst_n && expire_valid && expire_ready) rpt_q.push_back({expire_tid, expire_sci});

  function automatic bit is_exp(input logic [EW-1:0] e, input logic [15:0] now);
    logic [15:0] d;
    d = now - e[15:0];
    return e[16] && (d != 16'd0) && (d < 16'h8000);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [EW-1:0] v);
    ld_wr = 1'b1; ld_addr = a; ld_data = v;
    tick();
    ld_wr = 1'b0;
  endtask

  task automatic load_all_invalid();
    for (int i = 0; i < N; i++) load(i[AW-1:0], '0);
  endtask

  task automatic set_now(input logic [15:0] n);
    current_time = {n, 16'($urandom)};
  endtask

  task automatic stop_scan();
    scan_enable = 1'b0; expire_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!scan_busy) break;
    end
    tick(); tick();
  endtask

  task automatic run_pass(input bit rnd, output bit ok);
    ok = 1'b0;
    scan_enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      expire_ready = rnd ? 1'($urandom % 2) : 1'b1;
      tick();
      if (scan_done) begin ok = 1'b1; break; end
    end
    expire_ready = 1'b1;
    scan_enable = 1'b0;
  endtask

  task automatic wait_rd(input logic [AW-1:0] a, output bit found);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tset_ram_rd && tset_ram_raddr == a) begin found = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({tset_ram_rd, tset_ram_wr, expire_valid, scan_busy, scan_done} !== 5'b0) begin
      errors++; $display("FAIL rst_ctl: got %b expected 00000",
                         {tset_ram_rd, tset_ram_wr, expire_valid, scan_busy, scan_done});
    end
    checks++;
    if (expire_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0h expected 0", expire_cnt); end
    checks++;
    if ({tset_ram_raddr, tset_ram_waddr, tset_ram_wdata, expire_tid, expire_sci} !== '0) begin
      errors++; $display("FAIL rst_bus: raddr %0h waddr %0h wdata %0h expected 0",
                         tset_ram_raddr, tset_ram_waddr, tset_ram_wdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (scan_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", scan_busy); end
  endtask

  task automatic test_empty_pass();
    int rd_c[$]; logic [AW-1:0] rd_a[$]; int done_c; int nwr; bit seq_ok;
    load_all_invalid(); set_now(16'h0020); scan_gap = 16'd4; rpt_q.delete();
    done_c = -1; nwr = 0;
    scan_enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tset_ram_rd) begin rd_c.push_back(c); rd_a.push_back(tset_ram_raddr); end
      if (scan_done && done_c < 0) done_c = c;
      if (tset_ram_wr) nwr++;
    end
    stop_scan();
    checks++;
    if (rd_c.size() < 17) begin
      errors++; $display("FAIL empty_rdcount: got %0d expected >=17", rd_c.size());
    end else begin
      seq_ok = 1'b1;
      for (int i = 0; i < 16; i++)
        if (rd_a[i] != i[AW-1:0] || rd_c[i] != rd_c[0] + 2*i) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin errors++; $display("FAIL empty_rdseq: got %b expected 1", seq_ok); end
      checks++;
      if (done_c != rd_c[0] + 32) begin
        errors++; $display("FAIL empty_done: got %0d expected %0d", done_c, rd_c[0] + 32);
      end
      checks++;
      if (rd_c[16] != done_c + 5 || rd_a[16] != 4'd0) begin
        errors++; $display("FAIL empty_gap: got cyc %0d addr %0d expected %0d addr 0",
                           rd_c[16], rd_a[16], done_c + 5);
      end
    end
    checks++;
    if (nwr != 0 || rpt_q.size() != 0) begin
      errors++; $display("FAIL empty_wr: got writes %0d reports %0d expected 0 0", nwr, rpt_q.size());
    end
  endtask

  task automatic test_single_expire();
    bit found, idok; int vcnt; logic [15:0] cnt0;
    load_all_invalid(); load(4'd5, {1'b1, 16'h0010}); set_now(16'h0020);
    scan_gap = 16'd0; cnt0 = expire_cnt; rpt_q.delete();
    expire_ready = 1'b0; scan_enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (expire_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL exp_wait: got no expire_valid expected one"); end
    vcnt = found ? 1 : 0;
    idok = found && expire_tid == 2'd1 && expire_sci == 2'd1;
    for (int i = 0; i < 10 && found; i++) begin
      if (vcnt == 4) expire_ready = 1'b1;
      tick();
      if (!expire_valid) break;
      vcnt++;
      if (expire_tid != 2'd1 || expire_sci != 2'd1) idok = 1'b0;
    end
    checks++;
    if (vcnt != 4) begin errors++; $display("FAIL exp_hold: got %0d clks expected 4", vcnt); end
    checks++;
    if (!idok) begin errors++; $display("FAIL exp_id: got tid %0d sci %0d expected 1 1", expire_tid, expire_sci); end
    checks++;
    if (expire_cnt !== cnt0 + 16'd1) begin errors++; $display("FAIL exp_cnt: got %0d expected %0d", expire_cnt, cnt0 + 16'd1); end
    stop_scan();
    checks++;
    if (ram[5] !== 17'h0) begin errors++; $display("FAIL exp_ram: got %0h expected 0", ram[5]); end
    checks++;
    if (rpt_q.size() != 1 || rpt_q[0] != 4'd5) begin
      errors++; $display("FAIL exp_rpt: got %0d reports expected 1 at addr 5", rpt_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok; logic [15:0] cnt0;
    load_all_invalid(); load(4'd6, {1'b1, 16'h0030}); set_now(16'h0020);
    rpt_q.delete(); cnt0 = expire_cnt; scan_gap = 16'd1;
    run_pass(1'b0, ok); stop_scan();
    checks++;
    if (!ok || rpt_q.size() != 0 || ram[6] !== {1'b1, 16'h0030}) begin
      errors++; $display("FAIL future_keep: got done %b reports %0d ram6 %0h expected 1 0 10030",
                         ok, rpt_q.size(), ram[6]);
    end
    load(4'd7, {1'b1, 16'hFFF0}); set_now(16'h0005);
    run_pass(1'b0, ok); stop_scan();
    checks++;
    if (!ok || rpt_q.size() != 1 || rpt_q[0] != 4'd7) begin
      errors++; $display("FAIL wrap_rpt: got done %b reports %0d expected 1 1 at addr 7", ok, rpt_q.size());
    end
    checks++;
    if (ram[7] !== 17'h0 || ram[6] !== {1'b1, 16'h0030}) begin
      errors++; $display("FAIL wrap_ram: got ram7 %0h ram6 %0h expected 0 10030", ram[7], ram[6]);
    end
    checks++;
    if (expire_cnt !== cnt0 + 16'd1) begin errors++; $display("FAIL wrap_cnt: got %0d expected %0d", expire_cnt, cnt0 + 16'd1); end
  endtask

  task automatic test_refresh_eval();
    bit found, ok; logic [15:0] cnt0;
    load_all_invalid(); load(4'd5, {1'b1, 16'h0010}); set_now(16'h0020);
    rpt_q.delete(); cnt0 = expire_cnt; scan_gap = 16'd0;
    scan_enable = 1'b1;
    wait_rd(4'd5, found);
    tick();
    tset_wr = 1'b1; tset_waddr = 4'd5; tset_wdata = 16'h0100;
    tick();
    tset_wr = 1'b0;
    run_pass(1'b0, ok); stop_scan();
    checks++;
    if (!found || !ok) begin errors++; $display("FAIL refr_seq: got rd %b done %b expected 1 1", found, ok); end
    checks++;
    if (ram[5] !== {1'b1, 16'h0100}) begin errors++; $display("FAIL refr_ram: got %0h expected 10100", ram[5]); end
    checks++;
    if (rpt_q.size() != 0 || expire_cnt !== cnt0) begin
      errors++; $display("FAIL refr_rpt: got reports %0d cnt %0d expected 0 %0d", rpt_q.size(), expire_cnt, cnt0);
    end
  endtask

  task automatic test_clr_stall();
    bit found, ok;
    load_all_invalid(); load(4'd5, {1'b1, 16'h0010}); set_now(16'h0020);
    rpt_q.delete(); scan_gap = 16'd0;
    scan_enable = 1'b1;
    wait_rd(4'd5, found);
    tick(); tick();
    tset_wr = 1'b1; tset_waddr = 4'd9; tset_wdata = 16'h0200;
    #1;
    checks++;
    if (!found || !tset_ram_wr || tset_ram_waddr != 4'd9 || tset_ram_wdata != {1'b1, 16'h0200}) begin
      errors++; $display("FAIL stall_refr: got wr %b addr %0d data %0h expected 1 9 10200",
                         tset_ram_wr, tset_ram_waddr, tset_ram_wdata);
    end
    tick();
    tset_wr = 1'b0;
    #1;
    checks++;
    if (!tset_ram_wr || tset_ram_waddr != 4'd5 || tset_ram_wdata != 17'h0) begin
      errors++; $display("FAIL stall_clr: got wr %b addr %0d data %0h expected 1 5 0",
                         tset_ram_wr, tset_ram_waddr, tset_ram_wdata);
    end
    run_pass(1'b0, ok); stop_scan();
    checks++;
    if (ram[9] !== {1'b1, 16'h0200} || ram[5] !== 17'h0) begin
      errors++; $display("FAIL stall_ram: got ram9 %0h ram5 %0h expected 10200 0", ram[9], ram[5]);
    end
    checks++;
    if (rpt_q.size() != 1 || rpt_q[0] != 4'd5) begin
      errors++; $display("FAIL stall_rpt: got %0d reports expected 1 at addr 5", rpt_q.size());
    end
  endtask

  task automatic test_enable_drop();
    bit found; int nrd, nd;
    load_all_invalid(); rpt_q.delete(); scan_gap = 16'd0;
    scan_enable = 1'b1;
    wait_rd(4'd3, found);
    tick();
    scan_enable = 1'b0;
    nrd = 0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (tset_ram_rd) nrd++;
      if (scan_done) nd++;
    end
    checks++;
    if (!found || nrd != 0 || nd != 0 || scan_busy) begin
      errors++; $display("FAIL drop_idle: got rd %0d done %0d busy %b expected 0 0 0", nrd, nd, scan_busy);
    end
    scan_enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tset_ram_rd) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || tset_ram_raddr != 4'd0) begin
      errors++; $display("FAIL drop_restart: got rd %b addr %0d expected 1 0", found, tset_ram_raddr);
    end
    stop_scan();
  endtask

  task automatic test_reset_notify();
    bit found;
    load_all_invalid(); load(4'd5, {1'b1, 16'h0010}); set_now(16'h0020);
    scan_gap = 16'd0; expire_ready = 1'b0; scan_enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (expire_valid) begin found = 1'b1; break; end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || expire_valid || scan_busy || expire_cnt !== 16'd0) begin
      errors++; $display("FAIL rstn_async: got valid %b busy %b cnt %0d expected 0 0 0",
                         expire_valid, scan_busy, expire_cnt);
    end
    expire_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tset_ram_rd) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || tset_ram_raddr != 4'd0) begin
      errors++; $display("FAIL rstn_restart: got rd %b addr %0d expected 1 0", found, tset_ram_raddr);
    end
    stop_scan();
  endtask

  task automatic test_random();
    logic [EW-1:0] model [N];
    logic [AW-1:0] exp_q [$];
    logic [15:0] now, cnt0, e;
    bit ok, match;
    for (int it = 0; it < 4; it++) begin
      now = 16'($urandom);
      set_now(now);
      exp_q.delete();
      for (int a = 0; a < N; a++) begin
        e = now + 16'($urandom_range(0, 80)) - 16'd40;
        if ($urandom % 4 == 0) e = 16'($urandom);
        model[a] = {1'($urandom % 4 != 0), e};
        load(a[AW-1:0], model[a]);
        if (is_exp(model[a], now)) begin
          exp_q.push_back(a[AW-1:0]);
          model[a] = '0;
        end
      end
      scan_gap = 16'($urandom_range(0, 5));
      cnt0 = expire_cnt; rpt_q.delete();
      run_pass(1'b1, ok); stop_scan();
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_done: iter %0d got no scan_done expected one", it); end
      match = (rpt_q.size() == exp_q.size());
      for (int i = 0; i < exp_q.size() && match; i++) if (rpt_q[i] != exp_q[i]) match = 1'b0;
      checks++;
      if (!match) begin
        errors++; $display("FAIL rnd_rpt: iter %0d got %0d reports expected %0d", it, rpt_q.size(), exp_q.size());
      end
      checks++;
      if (expire_cnt !== cnt0 + 16'(exp_q.size())) begin
        errors++; $display("FAIL rnd_cnt: iter %0d got %0d expected %0d", it, expire_cnt, cnt0 + 16'(exp_q.size()));
      end
      match = 1'b1;
      for (int a = 0; a < N; a++) if (ram[a] !== model[a]) match = 1'b0;
      checks++;
      if (!match) begin errors++; $display("FAIL rnd_ram: iter %0d got table differing from model expected equal", it); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; current_time = '0; scan_enable = 1'b0; scan_gap = '0;
    tset_wr = 1'b0; tset_waddr = '0; tset_wdata = '0; expire_ready = 1'b1;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_empty_pass();
    test_single_expire();
    test_wrap();
    test_refresh_eval();
    test_clr_stall();
    test_enable_drop();
    test_reset_notify();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
